// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core controller: FSM states, instruction
// bit positions, the idle-safe instruction word and the latched job setup.
package core_ctrl_pkg;

  localparam int INST_W = 35;
  localparam int ADDR_W = 11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WFETCH = 3'd1,
    S_WLOAD  = 3'd2,
    S_XFETCH = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  // Instruction word bit positions
  localparam int BIT_MODE     = 34;
  localparam int BIT_ACC      = 33;
  localparam int BIT_CEN_P    = 32;
  localparam int BIT_WEN_P    = 31;
  localparam int A_PMEM_LSB   = 20;
  localparam int BIT_CEN_X    = 19;
  localparam int BIT_WEN_X    = 18;
  localparam int A_XMEM_LSB   = 7;
  localparam int BIT_OFIFO_RD = 6;
  localparam int BIT_L0_RD    = 3;
  localparam int BIT_L0_WR    = 2;
  localparam int BIT_EXEC     = 1;
  localparam int BIT_LOAD     = 0;

  // Both SRAMs deselected and write-protected, everything else quiet
  localparam logic [INST_W-1:0] INST_IDLE = (INST_W'(1) << BIT_CEN_P) |
                                            (INST_W'(1) << BIT_WEN_P) |
                                            (INST_W'(1) << BIT_CEN_X) |
                                            (INST_W'(1) << BIT_WEN_X);

  // Job configuration captured when a start is accepted
  typedef struct packed {
    logic              mode_2b;
    logic [3:0]        num_k;
    logic [ADDR_W-1:0] n_act;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] x_base;
    logic [ADDR_W-1:0] p_base;
  } cfg_t;

  // A zero activation count would make the tile loops degenerate; run one vector instead
  function automatic logic [ADDR_W-1:0] clamp_n_act(input logic [ADDR_W-1:0] n);
    return (n == '0) ? ADDR_W'(1) : n;
  endfunction

endpackage

// File: rtl/core_ctrl_addr_gen.sv
// Registered SRAM address generator: base + offset with 11-bit wrap.
// Output is forced to zero when not enabled so idle instructions carry no address.
module core_ctrl_addr_gen
  import core_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] offset,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] addr_q;

  // Sum wraps naturally at 2048 because it is truncated to ADDR_W bits
  always_comb begin
    addr_d = '0;
    if (en) begin
      addr_d = base + offset;
    end
  end

  // Address register feeding the instruction word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/core_ctrl.sv
// Core controller: sequences weight fetch/load, activation fetch, execute and
// result writeback for num_k+1 kernel tiles, emitting one registered
// instruction word per cycle. The instruction reflects the FSM state of the
// previous cycle, so every bit (addresses included) comes straight from flops.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int inst_w = 35
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_2b_cfg,
  input  logic [3:0]        num_k,
  input  logic [10:0]       n_act,
  input  logic [10:0]       w_base,
  input  logic [10:0]       x_base,
  input  logic [10:0]       p_base,
  input  logic              ofifo_valid,
  output logic [inst_w-1:0] inst,
  output logic              busy,
  output logic              done
);

  // Counter must reach n_act + row + col - 1 in EXEC
  localparam int CNT_W = $clog2(2048 + row + col);
  localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(row);
  localparam logic [CNT_W-1:0] PIPE_LAST = CNT_W'(row + col - 1);

  state_t            state_q, state_d;
  logic [3:0]        k_q, k_d;
  logic [CNT_W-1:0]  i_q, i_d;
  cfg_t              cfg_q, cfg_d;

  logic [inst_w-1:0] ctrl_q, ctrl_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              xa_en;
  logic [ADDR_W-1:0] xa_base;
  logic [ADDR_W-1:0] xa_off;
  logic              pa_en;
  logic [ADDR_W-1:0] pa_off;
  logic [ADDR_W-1:0] a_xmem;
  logic [ADDR_W-1:0] a_pmem;

  logic [CNT_W-1:0]  n_ext;
  logic [CNT_W-1:0]  exec_last;

  assign n_ext     = CNT_W'(cfg_q.n_act);
  assign exec_last = n_ext + PIPE_LAST;

  // State, counters and latched configuration
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      i_q     <= '0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      i_q     <= i_d;
      cfg_q   <= cfg_d;
    end
  end

  // Next-state, tile/step counters and configuration capture
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    i_d     = i_q;
    cfg_d   = cfg_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WFETCH;
          k_d     = '0;
          i_d     = '0;
          cfg_d   = '{mode_2b: mode_2b_cfg,
                      num_k:   num_k,
                      n_act:   clamp_n_act(n_act),
                      w_base:  w_base,
                      x_base:  x_base,
                      p_base:  p_base};
        end
      end
      S_WFETCH: begin
        if (i_q == ROW_LAST) begin
          state_d = S_WLOAD;
          i_d     = '0;
        end else begin
          i_d = i_q + CNT_W'(1);
        end
      end
      S_WLOAD: begin
        if (i_q == PIPE_LAST) begin
          state_d = S_XFETCH;
          i_d     = '0;
        end else begin
          i_d = i_q + CNT_W'(1);
        end
      end
      S_XFETCH: begin
        if (i_q == n_ext) begin
          state_d = S_EXEC;
          i_d     = '0;
        end else begin
          i_d = i_q + CNT_W'(1);
        end
      end
      S_EXEC: begin
        if (i_q == exec_last) begin
          state_d = S_WB;
          i_d     = '0;
        end else begin
          i_d = i_q + CNT_W'(1);
        end
      end
      S_WB: begin
        // Only cycles with readable output data advance the write pointer
        if (ofifo_valid) begin
          if (i_q == n_ext - CNT_W'(1)) begin
            i_d = '0;
            if (k_q == cfg_q.num_k) begin
              state_d = S_DONE;
            end else begin
              k_d     = k_q + 4'd1;
              state_d = S_WFETCH;
            end
          end else begin
            i_d = i_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        k_d     = '0;
        i_d     = '0;
      end
      default: begin
        state_d = S_IDLE;
        k_d     = '0;
        i_d     = '0;
      end
    endcase
  end

  // Instruction control bits and address requests for the current state/step
  always_comb begin
    ctrl_d  = inst_w'(INST_IDLE);
    xa_en   = 1'b0;
    xa_base = '0;
    xa_off  = '0;
    pa_en   = 1'b0;
    pa_off  = '0;
    if (state_q != S_IDLE) begin
      ctrl_d[BIT_MODE] = cfg_q.mode_2b;
    end
    case (state_q)
      S_WFETCH: begin
        if (i_q < ROW_LAST) begin
          ctrl_d[BIT_CEN_X] = 1'b0;
          xa_en             = 1'b1;
          xa_base           = cfg_q.w_base;
          xa_off            = ADDR_W'(int'(k_q) * row + int'(i_q));
        end
        // SRAM read data arrives one cycle after the request
        if (i_q != '0) begin
          ctrl_d[BIT_L0_WR] = 1'b1;
        end
      end
      S_WLOAD: begin
        ctrl_d[BIT_LOAD] = 1'b1;
        if (i_q < ROW_LAST) begin
          ctrl_d[BIT_L0_RD] = 1'b1;
        end
      end
      S_XFETCH: begin
        if (i_q < n_ext) begin
          ctrl_d[BIT_CEN_X] = 1'b0;
          xa_en             = 1'b1;
          xa_base           = cfg_q.x_base;
          xa_off            = ADDR_W'(i_q);
        end
        if (i_q != '0) begin
          ctrl_d[BIT_L0_WR] = 1'b1;
        end
      end
      S_EXEC: begin
        ctrl_d[BIT_EXEC] = 1'b1;
        ctrl_d[BIT_ACC]  = (k_q != '0);
        if (i_q < n_ext) begin
          ctrl_d[BIT_L0_RD] = 1'b1;
        end
      end
      S_WB: begin
        if (ofifo_valid) begin
          ctrl_d[BIT_OFIFO_RD] = 1'b1;
          ctrl_d[BIT_CEN_P]    = 1'b0;
          ctrl_d[BIT_WEN_P]    = 1'b0;
          pa_en                = 1'b1;
          pa_off               = ADDR_W'(i_q);
        end
      end
      default: begin
      end
    endcase
  end

  // Busy drops in the same cycle the done pulse is presented
  always_comb begin
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // Output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= inst_w'(INST_IDLE);
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  core_ctrl_addr_gen u_xmem_addr (
    .clk    (clk),
    .rst_n  (reset),
    .en     (xa_en),
    .base   (xa_base),
    .offset (xa_off),
    .addr   (a_xmem)
  );

  core_ctrl_addr_gen u_pmem_addr (
    .clk    (clk),
    .rst_n  (reset),
    .en     (pa_en),
    .base   (cfg_q.p_base),
    .offset (pa_off),
    .addr   (a_pmem)
  );

  // Address fields of ctrl_q are always zero, so OR-merging is exact
  assign inst = ctrl_q
              | (inst_w'(a_pmem) << A_PMEM_LSB)
              | (inst_w'(a_xmem) << A_XMEM_LSB);
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Testbench for core_ctrl: job table plus hand sequences for writeback
// stalls, start while busy and reset during a job.
module tb_core_ctrl;

  localparam logic [34:0] IDLE_INST = 35'h1800C0000;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mode_2b_cfg;
  logic [3:0]  num_k;
  logic [10:0] n_act;
  logic [10:0] w_base;
  logic [10:0] x_base;
  logic [10:0] p_base;
  logic        ofifo_valid;
  logic [34:0] inst;
  logic        busy;
  logic        done;

  core_ctrl #(.row(8), .col(8), .inst_w(35)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode_2b_cfg (mode_2b_cfg),
    .num_k       (num_k),
    .n_act       (n_act),
    .w_base      (w_base),
    .x_base      (x_base),
    .p_base      (p_base),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  nk;
    logic [10:0] na;
    logic [10:0] wb;
    logic [10:0] xb;
    logic [10:0] pb;
    logic        md;
    int          vmode;    // 0: ofifo_valid=1, 1: random, 2: manual
    int          exp_exec;
    int          exp_pw;
  } job_t;

  job_t jobs[4];
  job_t hj;

  int checks;
  int errors;

  logic [10:0] exp_x[$];
  logic [10:0] exp_p[$];

  int   vld_mode;
  logic man_vld;
  int   exec_cnt, pw_cnt, load_cnt, done_cnt, xrd_cnt;
  int   s_exec, s_pw, s_load, s_done, s_xrd;
  int   exec_base;
  int   cur_neff;
  logic cur_mode;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string detail);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, detail);
  endtask

  // Per-cycle observation of the instruction stream against the scoreboard
  task automatic monitor();
    logic [10:0] ax;
    logic [10:0] ap;
    logic [10:0] e;
    int          tile;
    ax = inst[17:7];
    ap = inst[30:20];
    check("ififo_bits", inst[5:4], 2'b00);
    if (inst[19] == 1'b0) begin
      xrd_cnt++;
      check("xmem_wen", inst[18], 1'b1);
      if (exp_x.size() == 0) begin
        fail_now("xmem_unexpected", $sformatf("read at %0d, expected no read", ax));
      end else begin
        e = exp_x.pop_front();
        check("xmem_addr", ax, e);
      end
    end
    if (inst[32] == 1'b0) begin
      pw_cnt++;
      check("pmem_wen", inst[31], 1'b0);
      check("ofifo_rd", inst[6], 1'b1);
      if (exp_p.size() == 0) begin
        fail_now("pmem_unexpected", $sformatf("write at %0d, expected no write", ap));
      end else begin
        e = exp_p.pop_front();
        check("pmem_addr", ap, e);
      end
    end
    if (inst[0]) load_cnt++;
    if (inst[1]) begin
      tile = (exec_cnt - exec_base) / (cur_neff + 16);
      check("acc", inst[33], tile != 0);
      exec_cnt++;
    end
    if (!inst[19] || inst[0] || inst[1] || !inst[32]) begin
      check("mode_bit", inst[34], cur_mode);
    end
    if (done) begin
      done_cnt++;
      check("busy_at_done", busy, 1'b0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
    @(negedge clk);
    case (vld_mode)
      0:       ofifo_valid = 1'b1;
      1:       ofifo_valid = 1'($urandom_range(0, 1));
      default: ofifo_valid = man_vld;
    endcase
  endtask

  task automatic launch(input job_t j);
    s_exec    = exec_cnt;
    s_pw      = pw_cnt;
    s_load    = load_cnt;
    s_done    = done_cnt;
    s_xrd     = xrd_cnt;
    exec_base = exec_cnt;
    cur_mode  = j.md;
    cur_neff  = (j.na == 11'd0) ? 1 : int'(j.na);
    for (int t = 0; t <= int'(j.nk); t++) begin
      for (int r = 0; r < 8; r++) exp_x.push_back(11'(int'(j.wb) + t * 8 + r));
      for (int a = 0; a < cur_neff; a++) exp_x.push_back(11'(int'(j.xb) + a));
      for (int a = 0; a < cur_neff; a++) exp_p.push_back(11'(int'(j.pb) + a));
    end
    vld_mode    = j.vmode;
    num_k       = j.nk;
    n_act       = j.na;
    w_base      = j.wb;
    x_base      = j.xb;
    p_base      = j.pb;
    mode_2b_cfg = j.md;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    // Inputs change after start; the job must keep its latched setup
    num_k       = 4'($urandom);
    n_act       = 11'($urandom);
    w_base      = 11'($urandom);
    x_base      = 11'($urandom);
    p_base      = 11'($urandom);
    mode_2b_cfg = ~j.md;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == s_done && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == s_done) fail_now("done_timeout", "no done pulse, expected one");
  endtask

  task automatic finish_job(input job_t j);
    tick();
    tick();
    check("idle_inst", inst, IDLE_INST);
    check("busy_idle", busy, 1'b0);
    check("done_pulses", done_cnt - s_done, 1);
    check("exec_cycles", exec_cnt - s_exec, j.exp_exec);
    check("pmem_writes", pw_cnt - s_pw, j.exp_pw);
    check("load_cycles", load_cnt - s_load, (int'(j.nk) + 1) * 16);
    check("xmem_left", exp_x.size(), 0);
    check("pmem_left", exp_p.size(), 0);
    exp_x.delete();
    exp_p.delete();
  endtask

  task automatic run_job(input job_t j);
    launch(j);
    wait_done(3000);
    finish_job(j);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks = 0; errors = 0;
    exec_cnt = 0; pw_cnt = 0; load_cnt = 0; done_cnt = 0; xrd_cnt = 0;
    s_exec = 0; s_pw = 0; s_load = 0; s_done = 0; s_xrd = 0;
    exec_base = 0; cur_neff = 1; cur_mode = 1'b0;
    vld_mode = 2; man_vld = 1'b0;
    reset = 1'b0; start = 1'b0; mode_2b_cfg = 1'b0; num_k = '0; n_act = '0;
    w_base = '0; x_base = '0; p_base = '0; ofifo_valid = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_inst", inst, IDLE_INST);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    reset = 1'b1;
    tick();
    check("post_rst_inst", inst, IDLE_INST);

    jobs[0] = '{nk: 4'd0, na: 11'd4, wb: 11'd0,    xb: 11'd64,   pb: 11'd0,
                md: 1'b0, vmode: 0, exp_exec: 20, exp_pw: 4};
    jobs[1] = '{nk: 4'd2, na: 11'd2, wb: 11'd0,    xb: 11'd100,  pb: 11'd200,
                md: 1'b0, vmode: 1, exp_exec: 54, exp_pw: 6};
    jobs[2] = '{nk: 4'd1, na: 11'd1, wb: 11'd2044, xb: 11'd2046, pb: 11'd2047,
                md: 1'b1, vmode: 0, exp_exec: 34, exp_pw: 2};
    jobs[3] = '{nk: 4'd0, na: 11'd0, wb: 11'd5,    xb: 11'd7,    pb: 11'd9,
                md: 1'b1, vmode: 1, exp_exec: 17, exp_pw: 1};

    for (int i = 0; i < 4; i++) run_job(jobs[i]);

    // Writeback stalls: valid 1,0,0,1 with nothing written while it is low
    hj = '{nk: 4'd0, na: 11'd2, wb: 11'd16, xb: 11'd32, pb: 11'd0,
           md: 1'b0, vmode: 2, exp_exec: 18, exp_pw: 2};
    man_vld = 1'b0;
    launch(hj);
    n = 0;
    while (exec_cnt - s_exec < 18 && n < 300) begin tick(); n++; end
    if (exec_cnt - s_exec < 18) fail_now("exec_timeout", "execute phase incomplete, expected 18 cycles");
    repeat (8) tick();
    check("wb_stall_writes", pw_cnt - s_pw, 0);
    check("wb_stall_busy", busy, 1'b1);
    man_vld = 1'b1; tick();
    man_vld = 1'b0; tick();
    check("wb_first_write", pw_cnt - s_pw, 1);
    tick();
    man_vld = 1'b1; tick();
    check("wb_gap_writes", pw_cnt - s_pw, 1);
    man_vld = 1'b0; tick();
    wait_done(50);
    finish_job(hj);

    // Start during EXEC must be ignored
    hj = '{nk: 4'd0, na: 11'd3, wb: 11'd40, xb: 11'd80, pb: 11'd120,
           md: 1'b0, vmode: 0, exp_exec: 19, exp_pw: 3};
    launch(hj);
    n = 0;
    while (exec_cnt - s_exec < 5 && n < 300) begin tick(); n++; end
    if (exec_cnt - s_exec < 5) fail_now("exec_timeout2", "execute not reached, expected 5 cycles");
    num_k = 4'd3; n_act = 11'd9; w_base = 11'd500; x_base = 11'd600;
    p_base = 11'd700; mode_2b_cfg = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(3000);
    finish_job(hj);
    repeat (20) tick();
    check("no_restart_busy", busy, 1'b0);
    check("no_restart_inst", inst, IDLE_INST);

    // Reset during XFETCH aborts, then a fresh job runs normally
    hj = '{nk: 4'd0, na: 11'd4, wb: 11'd0, xb: 11'd300, pb: 11'd0,
           md: 1'b1, vmode: 0, exp_exec: 20, exp_pw: 4};
    launch(hj);
    n = 0;
    while (xrd_cnt - s_xrd < 9 && n < 300) begin tick(); n++; end
    if (xrd_cnt - s_xrd < 9) fail_now("xfetch_timeout", "activation read not seen, expected one");
    reset = 1'b0;
    #1;
    check("abort_inst", inst, IDLE_INST);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    exp_x.delete();
    exp_p.delete();
    tick();
    check("abort_inst_next", inst, IDLE_INST);
    reset = 1'b1;
    tick();
    run_job(jobs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_ctrl.md
CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 Parameters SHALL be: row, default 8, MAC array rows; col, default 8, MAC array columns; inst_w, default 35, core instruction width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 start  input  1  one-cycle pulse that launches a job; sampled only in IDLE.
REQ-005 mode_2b_cfg  input  1  SIMD lane mode for the job, latched at start.
REQ-006 num_k  input  4  number of kernel tiles minus 1 (1..16 tiles), latched at start.
REQ-007 n_act  input  11  activation vectors per tile (1..2047; 0 is treated as 1), latched at start.
REQ-008 w_base, x_base, p_base  input  11 each  xmem weight, xmem activation and pmem result base addresses, latched at start.
REQ-009 ofifo_valid  input  1  core output FIFO holds readable data.
REQ-010 inst  output  35  core instruction: [34] mode_2b, [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
REQ-011 busy  output  1  high from the cycle after an accepted start until done.
REQ-012 done  output  1  one-cycle pulse when the last tile writeback completes.

Function
REQ-013 States SHALL be IDLE, WFETCH, WLOAD, XFETCH, EXEC, WB and DONE; k is the tile counter and i is the per-state counter; both clear on every state entry.
REQ-014 IDLE: inst SHALL be idle-safe (CEN_pmem=1, WEN_pmem=1, CEN_xmem=1, WEN_xmem=1, all other bits 0); start=1 -> WFETCH with k=0.
REQ-015 WFETCH, i=0..row: for i<row drive CEN_xmem=0, WEN_xmem=1, A_xmem=w_base+k*row+i; for i>=1 drive l0_wr=1 to cover the 1-cycle SRAM read latency; at i=row -> WLOAD.
REQ-016 WLOAD, i=0..row+col-1: load=1 throughout; l0_rd=1 for i<row; at i=row+col-1 -> XFETCH.
REQ-017 XFETCH, i=0..n_act: for i<n_act drive CEN_xmem=0, WEN_xmem=1, A_xmem=x_base+i; for i>=1 drive l0_wr=1; at i=n_act -> EXEC.
REQ-018 EXEC, i=0..n_act+row+col-1: execute=1 throughout; l0_rd=1 for i<n_act; acc=1 iff k!=0; at the last i -> WB.
REQ-019 WB: in every cycle with ofifo_valid=1, drive ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=p_base+i, then i++; with ofifo_valid=0 the state SHALL hold idle-safe and wait indefinitely.
REQ-020 WB exit: after n_act writes, if k==num_k -> DONE, otherwise k++ and -> WFETCH.
REQ-021 DONE: done=1 for one cycle, then -> IDLE; busy SHALL fall in the same cycle that done is high.
REQ-022 inst[34] SHALL equal latched mode_2b in every non-IDLE state; ififo_wr and ififo_rd SHALL always be 0.
REQ-023 All address sums SHALL be 11-bit, modulo 2048 (wrap without error).
REQ-024 start while busy SHALL be ignored, and latched configuration SHALL NOT change.
REQ-025 All inst bits SHALL come directly from registers (no combinational path from inputs to inst).

Reset
REQ-026 While reset=0: state=IDLE, k=i=0, busy=0, done=0, and inst idle-safe; latched configuration cleared to 0.
REQ-027 Reset asserted mid-job SHALL abort immediately; after release the block SHALL be in IDLE and accept a new start.

Structure
REQ-028 A shared package SHALL hold the state enum, the inst bit-position constants and the idle-safe inst constant.
REQ-029 One sub-module, core_ctrl_addr_gen (base + offset, 11-bit wrap, registered output), SHALL be instantiated for the xmem and pmem address paths.

Verification
REQ-030 num_k=0, n_act=4, w_base=0, x_base=64, p_base=0 -> exactly 8 weight reads at addresses 0..7, 4 activation reads at 64..67, execute high for 20 cycles, pmem writes at 0..3, then a single done pulse.
REQ-031 num_k=2, n_act=2 -> weight bases 0, 8 and 16 in successive tiles; acc=0 in tile 0 and 1 in tiles 1 and 2; 6 pmem writes in total.
REQ-032 WB with ofifo_valid toggling 1,0,0,1 -> writes only in valid cycles, A_pmem incrementing 0 then 1, with no skipped address.
REQ-033 w_base=2044, n_act=1 -> weight addresses 2044..2047, 0..3.
REQ-034 start pulsed during EXEC -> ignored, job completes unchanged; reset pulsed during XFETCH -> IDLE, idle-safe inst on the next cycle, and a new job runs correctly.
REQ-035 mode_2b_cfg=1 -> inst[34]=1 in all non-IDLE cycles and 0 in IDLE.
